// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: load-miss MSHR table, Dmem issue/return and cache fill.
// Entries allocate lowest-free, issue lowest-unissued, retire by memory tag.
module dcache_miss_ctrl #(
  parameter int MSHR_N = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_req_valid,
  input  logic [63:0] ld_req_addr,
  input  logic [3:0]  ld_req_lsq_idx,
  output logic        ld_req_ready,
  output logic [1:0]  Dmem_command,
  output logic [63:0] Dmem_addr,
  input  logic [3:0]  Dmem_response,
  input  logic [63:0] Dmem_data,
  input  logic [3:0]  Dmem_tag,
  output logic        fill_en,
  output logic [21:0] fill_tag,
  output logic [6:0]  fill_idx,
  output logic [63:0] fill_data,
  output logic        ld_done_valid,
  output logic [3:0]  ld_done_lsq_idx,
  output logic [63:0] ld_done_data,
  input  logic        halt_req,
  output logic        halt_done
);

  localparam int IW = (MSHR_N > 1) ? $clog2(MSHR_N) : 1;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_LOAD = 2'd1
  } dmem_cmd_e;

  typedef struct packed {
    logic        valid;
    logic        issued;
    logic [3:0]  mem_tag;
    logic [60:0] addr;
    logic [3:0]  lsq_idx;
  } mshr_t;

  mshr_t ent     [MSHR_N];
  mshr_t ent_nxt [MSHR_N];

  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          iss_found;
  logic [IW-1:0] iss_idx;
  logic          hit_found;
  logic [IW-1:0] hit_idx;
  logic          any_valid;
  logic          accept;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^ld_req_addr[2:0];

  // Downward scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    any_valid  = 1'b0;
    for (int i = MSHR_N - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (ent[i].valid && !ent[i].issued) begin
        iss_found = 1'b1;
        iss_idx   = IW'(i);
      end
      if (ent[i].valid && ent[i].issued &&
          Dmem_tag != 4'd0 &&
          ent[i].mem_tag == Dmem_tag) begin
        hit_found = 1'b1;
        hit_idx   = IW'(i);
      end
      if (ent[i].valid) begin
        any_valid = 1'b1;
      end
    end
  end

  assign ld_req_ready = free_found && !halt_req;
  assign accept       = ld_req_ready && ld_req_valid;

  always_comb begin
    Dmem_command = CMD_NONE;
    Dmem_addr    = '0;
    if (iss_found) begin
      Dmem_command = CMD_LOAD;
      Dmem_addr    = {ent[iss_idx].addr, 3'b000};
    end
  end

  always_comb begin
    for (int i = 0; i < MSHR_N; i++) begin
      ent_nxt[i] = ent[i];
    end
    if (hit_found) begin
      ent_nxt[hit_idx].valid = 1'b0;
    end
    if (iss_found && Dmem_response != 4'd0) begin
      ent_nxt[iss_idx].issued  = 1'b1;
      ent_nxt[iss_idx].mem_tag = Dmem_response;
    end
    if (accept) begin
      ent_nxt[free_idx].valid   = 1'b1;
      ent_nxt[free_idx].issued  = 1'b0;
      ent_nxt[free_idx].mem_tag = 4'd0;
      ent_nxt[free_idx].addr    = ld_req_addr[63:3];
      ent_nxt[free_idx].lsq_idx = ld_req_lsq_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_N; i++) begin
        ent[i] <= '0;
      end
      fill_en         <= 1'b0;
      fill_tag        <= '0;
      fill_idx        <= '0;
      fill_data       <= '0;
      ld_done_valid   <= 1'b0;
      ld_done_lsq_idx <= '0;
      ld_done_data    <= '0;
      halt_done       <= 1'b0;
    end else begin
      for (int i = 0; i < MSHR_N; i++) begin
        ent[i] <= ent_nxt[i];
      end
      fill_en       <= hit_found;
      ld_done_valid <= hit_found;
      // Stored addr drops bits [2:0], so line fields sit 3 lower.
      if (hit_found) begin
        fill_tag        <= ent[hit_idx].addr[28:7];
        fill_idx        <= ent[hit_idx].addr[6:0];
        fill_data       <= Dmem_data;
        ld_done_lsq_idx <= ent[hit_idx].lsq_idx;
        ld_done_data    <= Dmem_data;
      end
      halt_done <= halt_req && !any_valid;
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: directed plan plus random traffic checked
// against a per-cycle behavioural model of the MSHR table.
module tb_dcache_miss_ctrl;

  localparam int N = 4;

  logic        clock;
  logic        reset;
  logic        ld_req_valid;
  logic [63:0] ld_req_addr;
  logic [3:0]  ld_req_lsq_idx;
  logic        ld_req_ready;
  logic [1:0]  Dmem_command;
  logic [63:0] Dmem_addr;
  logic [3:0]  Dmem_response;
  logic [63:0] Dmem_data;
  logic [3:0]  Dmem_tag;
  logic        fill_en;
  logic [21:0] fill_tag;
  logic [6:0]  fill_idx;
  logic [63:0] fill_data;
  logic        ld_done_valid;
  logic [3:0]  ld_done_lsq_idx;
  logic [63:0] ld_done_data;
  logic        halt_req;
  logic        halt_done;

  dcache_miss_ctrl #(.MSHR_N(N)) dut (
    .clock(clock),
    .reset(reset),
    .ld_req_valid(ld_req_valid),
    .ld_req_addr(ld_req_addr),
    .ld_req_lsq_idx(ld_req_lsq_idx),
    .ld_req_ready(ld_req_ready),
    .Dmem_command(Dmem_command),
    .Dmem_addr(Dmem_addr),
    .Dmem_response(Dmem_response),
    .Dmem_data(Dmem_data),
    .Dmem_tag(Dmem_tag),
    .fill_en(fill_en),
    .fill_tag(fill_tag),
    .fill_idx(fill_idx),
    .fill_data(fill_data),
    .ld_done_valid(ld_done_valid),
    .ld_done_lsq_idx(ld_done_lsq_idx),
    .ld_done_data(ld_done_data),
    .halt_req(halt_req),
    .halt_done(halt_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference table: slot-indexed misses and expected registered outputs.
  bit          mv [N];
  bit          mi [N];
  logic [3:0]  mt [N];
  logic [63:0] ma [N];
  logic [3:0]  ml [N];
  bit          e_fill = 0;
  logic [21:0] e_tag  = '0;
  logic [6:0]  e_idx  = '0;
  logic [63:0] e_data = '0;
  logic [3:0]  e_lsq  = '0;
  bit          e_halt = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  function automatic int first_iss();
    for (int i = 0; i < N; i++) if (mv[i] && !mi[i]) return i;
    return -1;
  endfunction

  function automatic int find_tag(logic [3:0] t);
    if (t == 4'd0) return -1;
    for (int i = 0; i < N; i++) if (mv[i] && mi[i] && mt[i] == t) return i;
    return -1;
  endfunction

  function automatic int n_valid();
    int c = 0;
    for (int i = 0; i < N; i++) if (mv[i]) c++;
    return c;
  endfunction

  // A tag no outstanding issued miss currently holds.
  function automatic logic [3:0] pick_tag();
    logic [3:0] t;
    for (int k = 0; k < 200; k++) begin
      t = 4'($urandom_range(1, 15));
      if (find_tag(t) < 0) return t;
    end
    return 4'd15;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mi[i] = 0; mt[i] = '0; ma[i] = '0; ml[i] = '0;
    end
  end

  always @(negedge clock) begin : cmp_p
    int ff, fi, fh;
    logic [63:0] xa;
    #2;
    ff = first_free();
    fi = first_iss();
    xa = (fi >= 0) ? ma[fi] : 64'd0;
    chk("ready", ld_req_ready, (ff >= 0 && !halt_req) ? 1 : 0);
    chk("cmd", Dmem_command, (fi >= 0) ? 1 : 0);
    chk("addr", Dmem_addr, xa);
    chk("fill_en", fill_en, e_fill);
    chk("done_valid", ld_done_valid, e_fill);
    chk("halt_done", halt_done, e_halt);
    if (e_fill) begin
      chk("fill_tag", fill_tag, e_tag);
      chk("fill_idx", fill_idx, e_idx);
      chk("fill_data", fill_data, e_data);
      chk("done_data", ld_done_data, e_data);
      chk("done_lsq", ld_done_lsq_idx, e_lsq);
    end
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 0; mi[i] = 0;
      end
      e_fill = 0;
      e_halt = 0;
    end else begin
      fh = find_tag(Dmem_tag);
      e_halt = halt_req && (n_valid() == 0);
      e_fill = (fh >= 0);
      if (fh >= 0) begin
        e_tag  = ma[fh][31:10];
        e_idx  = ma[fh][9:3];
        e_data = Dmem_data;
        e_lsq  = ml[fh];
        mv[fh] = 0;
      end
      if (fi >= 0 && Dmem_response != 4'd0) begin
        mi[fi] = 1;
        mt[fi] = Dmem_response;
      end
      if (ff >= 0 && !halt_req && ld_req_valid) begin
        mv[ff] = 1;
        mi[ff] = 0;
        ma[ff] = {ld_req_addr[63:3], 3'b000};
        ml[ff] = ld_req_lsq_idx;
      end
    end
  end

  task automatic idle();
    ld_req_valid   = 1'b0;
    ld_req_addr    = '0;
    ld_req_lsq_idx = '0;
    Dmem_response  = '0;
    Dmem_tag       = '0;
    Dmem_data      = '0;
  endtask

  task automatic req(logic [63:0] a, logic [3:0] l);
    ld_req_valid   = 1'b1;
    ld_req_addr    = a;
    ld_req_lsq_idx = l;
  endtask

  initial begin
    int r;
    int q[$];
    reset    = 1'b1;
    halt_req = 1'b0;
    idle();
    repeat (2) @(negedge clock);

    // single miss
    reset = 1'b0;
    req(64'h1238, 4'd5);
    #1;
    chk("lit_rst_ready", ld_req_ready, 1);
    chk("lit_rst_cmd", Dmem_command, 0);
    chk("lit_rst_fill", fill_en, 0);
    chk("lit_rst_halt", halt_done, 0);
    @(negedge clock);
    idle();
    Dmem_response = 4'd3;
    #1;
    chk("lit_single_cmd", Dmem_command, 1);
    chk("lit_single_addr", Dmem_addr, 64'h1238);
    repeat (7) begin
      @(negedge clock);
      idle();
    end
    #1 chk("lit_single_none", Dmem_command, 0);
    @(negedge clock);
    Dmem_tag  = 4'd3;
    Dmem_data = 64'hDEAD;
    @(negedge clock);
    idle();
    #1;
    chk("lit_single_fill", fill_en, 1);
    chk("lit_single_idx", fill_idx, 7'h47);
    chk("lit_single_tag", fill_tag, 4);
    chk("lit_single_data", fill_data, 64'hDEAD);
    chk("lit_single_lsq", ld_done_lsq_idx, 5);

    // retry
    @(negedge clock);
    req(64'hABCD_0000_5678_9A0F, 4'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      idle();
      Dmem_response = (k == 3) ? 4'd7 : 4'd0;
      #1;
      chk("lit_retry_cmd", Dmem_command, 1);
      chk("lit_retry_addr", Dmem_addr, 64'hABCD_0000_5678_9A08);
    end
    @(negedge clock);
    idle();
    #1 chk("lit_retry_none", Dmem_command, 0);
    @(negedge clock);
    Dmem_tag  = 4'd7;
    Dmem_data = 64'h77;
    @(negedge clock);
    idle();
    #1 chk("lit_retry_lsq", ld_done_lsq_idx, 2);

    // full / out-of-order
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      idle();
      req(64'h1000 + 64'(k * 8), 4'(k + 1));
      #1 chk("lit_full_ready", ld_req_ready, 1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      idle();
      Dmem_response = 4'(k + 1);
    end
    @(negedge clock);
    idle();
    req(64'h2000, 4'd9);
    #1 chk("lit_full_notready", ld_req_ready, 0);
    @(negedge clock);
    Dmem_tag  = 4'd3;
    Dmem_data = 64'h33;
    #1 chk("lit_full_notready2", ld_req_ready, 0);
    @(negedge clock);
    Dmem_tag  = 4'd1;
    Dmem_data = 64'h11;
    #1;
    chk("lit_full_ready_back", ld_req_ready, 1);
    chk("lit_ooo_lsq3", ld_done_lsq_idx, 3);
    chk("lit_ooo_data3", ld_done_data, 64'h33);
    @(negedge clock);
    idle();
    Dmem_tag  = 4'd4;
    Dmem_data = 64'h44;
    #1 chk("lit_ooo_lsq1", ld_done_lsq_idx, 1);
    @(negedge clock);
    idle();
    Dmem_tag  = 4'd2;
    Dmem_data = 64'h22;
    #1 chk("lit_ooo_lsq4", ld_done_lsq_idx, 4);
    @(negedge clock);
    idle();
    #1 chk("lit_ooo_lsq2", ld_done_lsq_idx, 2);

    // stray tag
    @(negedge clock);
    idle();
    Dmem_tag = 4'd9;
    @(negedge clock);
    idle();
    #1 chk("lit_stray_fill", fill_en, 0);

    // reset mid-flight
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req(64'h3000, 4'd6);
    @(negedge clock);
    req(64'h3008, 4'd7);
    Dmem_response = 4'd1;
    @(negedge clock);
    idle();
    Dmem_response = 4'd2;
    @(negedge clock);
    idle();
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    Dmem_tag = 4'd1;
    #1 chk("lit_rstmid_ready", ld_req_ready, 1);
    @(negedge clock);
    idle();
    #1 chk("lit_rstmid_fill", fill_en, 0);

    // halt drain
    @(negedge clock);
    req(64'h4000, 4'd10);
    @(negedge clock);
    req(64'h4008, 4'd11);
    Dmem_response = 4'd5;
    @(negedge clock);
    idle();
    Dmem_response = 4'd6;
    @(negedge clock);
    idle();
    halt_req = 1'b1;
    req(64'h5000, 4'd12);
    #1 chk("lit_halt_ready", ld_req_ready, 0);
    @(negedge clock);
    idle();
    Dmem_tag = 4'd5;
    #1 chk("lit_halt_busy1", halt_done, 0);
    @(negedge clock);
    idle();
    Dmem_tag = 4'd6;
    #1 chk("lit_halt_busy2", halt_done, 0);
    @(negedge clock);
    idle();
    #1 chk("lit_halt_last_fill", fill_en, 1);
    @(negedge clock);
    #1 chk("lit_halt_done", halt_done, 1);
    @(negedge clock);
    halt_req = 1'b0;
    #1 chk("lit_halt_hold", halt_done, 1);
    @(negedge clock);
    #1 chk("lit_halt_fall", halt_done, 0);

    // random traffic
    repeat (4000) begin
      @(negedge clock);
      idle();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 2) halt_req = !halt_req;
      ld_req_valid   = 1'($urandom_range(0, 1));
      ld_req_addr    = {$urandom, $urandom};
      ld_req_lsq_idx = 4'($urandom);
      if (first_iss() >= 0 && $urandom_range(0, 9) < 6)
        Dmem_response = pick_tag();
      r = $urandom_range(0, 9);
      if (r < 4) begin
        q.delete();
        for (int i = 0; i < N; i++) if (mv[i] && mi[i]) q.push_back(i);
        if (q.size() > 0)
          Dmem_tag = mt[q[$urandom_range(0, q.size() - 1)]];
      end else if (r == 4) begin
        Dmem_tag = pick_tag();
      end
      Dmem_data = {$urandom, $urandom};
    end

    @(negedge clock);
    idle();
    reset    = 1'b0;
    halt_req = 1'b0;
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
